// File: rtl/birthday_display_pkg.sv
// Shared constants, digit type and packed-BCD helpers for birthday_display.
package birthday_display_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 3;
  localparam int BCD_MAX    = 9;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Digit 0 is the most significant nibble of the packed word.
  function automatic digit_t get_digit(input logic [NUM_DIGITS*DIGIT_W-1:0] word,
                                       input logic [IDX_W-1:0] i);
    return word[(NUM_DIGITS-1-int'(i))*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic bcd_ok(input logic [NUM_DIGITS*DIGIT_W-1:0] word);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (word[i*DIGIT_W +: DIGIT_W] > digit_t'(BCD_MAX)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/birthday_display_bcd_to_sevseg.sv
// Combinational BCD digit to 7-segment decode, active-high segments g..a.
module bcd_to_sevseg
  import birthday_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    case (digit)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/birthday_display.sv
// Registered 8-digit BCD date display with runtime reload and BCD legality check.
// Optional 7-segment output enabled by defining BIRTHDAY_SEVSEG_EN.
module birthday_display
  import birthday_display_pkg::*;
#(
  parameter logic [31:0] BIRTHDAY = 32'h2001_0523
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  idx,
  input  logic        ld_en,
  input  logic [31:0] ld_data,
  output logic [3:0]  out,
  output logic        bcd_err
`ifdef BIRTHDAY_SEVSEG_EN
  ,
  output logic [6:0]  seg
`endif
);

  logic [31:0] store;
  logic        ld_ok;

  always_comb begin
    ld_ok = bcd_ok(ld_data);
  end

  // Read uses the pre-load store, so a same-edge load shows up one edge later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      store   <= BIRTHDAY;
      out     <= '0;
      bcd_err <= 1'b0;
    end else begin
      out     <= get_digit(store, idx);
      bcd_err <= ld_en & ~ld_ok;
      if (ld_en && ld_ok) store <= ld_data;
    end
  end

`ifdef BIRTHDAY_SEVSEG_EN
  // Decoding the registered digit keeps seg aligned with out, including reset.
  bcd_to_sevseg u_sevseg (
    .digit (out),
    .seg   (seg)
  );
`endif

endmodule

// File: tb/tb_birthday_display.sv
// Self-checking bench for birthday_display: directed test-plan steps plus random traffic.
module tb_birthday_display;

  logic        CLK;
  logic        RST_N;
  logic [2:0]  idx;
  logic        ld_en;
  logic [31:0] ld_data;
  logic [3:0]  out;
  logic        bcd_err;
`ifdef BIRTHDAY_SEVSEG_EN
  logic [6:0]  seg;
`endif

  birthday_display dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .idx     (idx),
    .ld_en   (ld_en),
    .ld_data (ld_data),
    .out     (out),
    .bcd_err (bcd_err)
`ifdef BIRTHDAY_SEVSEG_EN
    ,
    .seg     (seg)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference date as plain decimal digits, index 0 = leading year digit.
  int model_d[8];
  int exp_out;
  int exp_err;

  function automatic void word_to_digits(input logic [31:0] w, output int d[8]);
    for (int i = 0; i < 8; i++) d[i] = int'((w >> (28 - 4*i)) & 32'hF);
  endfunction

  function automatic bit all_decimal(input logic [31:0] w);
    int d[8];
    word_to_digits(w, d);
    foreach (d[i]) if (d[i] > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    return tab[d];
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"}, int'(out), exp_out);
    check({tag, ".bcd_err"}, int'(bcd_err), exp_err);
`ifdef BIRTHDAY_SEVSEG_EN
    check({tag, ".seg"}, int'(seg), int'(seg_of(exp_out)));
`endif
  endtask

  // Predict from the current inputs, clock once, then compare 1 ns after the edge.
  task automatic step(input string tag);
    int nd[8];
    exp_out = model_d[idx];
    exp_err = (ld_en && !all_decimal(ld_data)) ? 1 : 0;
    if (ld_en && all_decimal(ld_data)) begin
      word_to_digits(ld_data, nd);
      model_d = nd;
    end
    @(posedge CLK);
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    int nd[8];
    word_to_digits(32'h2001_0523, nd);
    model_d = nd;
    exp_out = 0;
    exp_err = 0;
  endtask

  // Mid-cycle async reset pulse, checked before any clock edge occurs.
  task automatic reset_pulse(input string tag);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(posedge CLK);
    #1;
    check_outputs({tag, ".held"});
    RST_N = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    int nd[8];
    RST_N   = 1'b0;
    idx     = '0;
    ld_en   = 1'b0;
    ld_data = '0;
    model_reset();
    #2;
    check_outputs("por");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Default date scan and wrap.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      step($sformatf("scan_def%0d", i));
    end
    idx = 3'd0;
    step("wrap0");

    // Non-zero output so the reset pulse visibly clears it.
    reset_pulse("rst_a");

    // Valid load at idx 4: old digit shown, new date from next edge.
    idx = 3'd4; ld_en = 1'b1; ld_data = 32'h1999_1231;
    step("load_valid");
    ld_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      step($sformatf("scan_new%0d", i));
    end

    // Reset after load restores the default date.
    reset_pulse("rst_b");
    idx = 3'd0;
    step("rst_restore");

    // Rejected load: one-cycle error, store untouched.
    idx = 3'd5; ld_en = 1'b1; ld_data = 32'h2001_0A23;
    step("load_bad");
    ld_en = 1'b0;
    step("after_bad");
    idx = 3'd0;
    step("after_bad_idx0");

    // Month 13 is BCD-legal and must be accepted.
    ld_en = 1'b1; ld_data = 32'h2024_1399; idx = 3'd7;
    step("load_cal");
    ld_en = 1'b0; idx = 3'd4;
    step("cal_m1");
    idx = 3'd5;
    step("cal_m3");

    // Random traffic: mix of legal dates and arbitrary words.
    for (int n = 0; n < 300; n++) begin
      idx   = 3'($urandom_range(0, 7));
      ld_en = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        w = '0;
        for (int k = 0; k < 8; k++) w = (w << 4) | 32'($urandom_range(0, 9));
      end else begin
        w = $urandom;
      end
      ld_data = w;
      step($sformatf("rnd%0d", n));
      if (n == 150) begin
        ld_en = 1'b0;
        reset_pulse("rst_rnd");
      end
    end

    word_to_digits(32'h0, nd);
    ld_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/birthday_display.md
Name: birthday_display

Overview:
- Birthday digit display. Holds an 8-digit BCD date (YYYYMMDD) and outputs the digit selected by a 3-bit index.
- Typically driven by a free-running 3-bit scan counter, so the date is shown one digit per cycle.
- Sits between the scan counter and the display driver. The output is registered; the date can be reloaded at runtime.

Parameters:
- BIRTHDAY, 32'h2001_0523, reset-time date as 8 packed BCD nibbles. Nibble [31:28] is digit index 0; nibble [3:0] is index 7.

Ports:
- CLK  input  1  single clock; everything samples on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- idx  input  3  digit select, 0..7 (0 = most significant year digit).
- ld_en  input  1  load strobe for a new date.
- ld_data  input  32  new date, packed BCD, same nibble order as BIRTHDAY.
- out  output  4  selected BCD digit, registered.
- bcd_err  output  1  one-cycle pulse: the load was rejected because a nibble was > 9.

Behaviour:
- Reset (RST_N low, asynchronous):
  - digit store = BIRTHDAY.
  - out = 4'd0, bcd_err = 0.
  - Held while RST_N is low; release is synchronised to the next CLK edge.
- Read path:
  - At each rising edge, out <= store[idx] (digit idx = nibble bits [31-4*idx -: 4]).
  - Latency is one cycle; out is updated every cycle and has no valid qualifier.
  - All 8 indices are legal. idx wrapping 7->0 needs no special handling.
- Load path:
  - On an edge with ld_en = 1, all 8 nibbles of ld_data are checked.
  - All nibbles <= 9: the store is replaced on that edge and bcd_err <= 0.
  - Any nibble > 9: the store is unchanged and bcd_err <= 1 for exactly one cycle.
  - With ld_en = 0, bcd_err <= 0.
- Simultaneous load and read on the same edge: out takes the old store contents. The new date is visible from the next edge.
- No calendar validation (e.g. month 13 made of BCD-legal digits is accepted); only BCD legality is checked.
- Reset during operation discards any loaded date and returns to BIRTHDAY.

Optional Feature:
- Macro BIRTHDAY_SEVSEG_EN.
- Defined: adds output seg[6:0], active-high segments g..a for the same registered digit, updated on the same edge as out.
  - Reset value is the pattern for 0, 7'b0111111.
- Undefined: no seg port; behaviour otherwise identical.

Decomposition:
- Package birthday_display_pkg holds:
  - NUM_DIGITS = 8, DIGIT_W = 4, IDX_W = 3, BCD_MAX = 9.
  - A digit typedef (logic [3:0]).
  - A function extracting nibble i from the packed 32-bit word.
- One natural sub-module: bcd_to_sevseg, combinational digit-to-7-segment decode, instantiated only under BIRTHDAY_SEVSEG_EN.

Test Plan:
- Reset: assert RST_N = 0 mid-cycle -> out = 0 and bcd_err = 0 immediately, without a clock edge.
- Scan with default BIRTHDAY: sweep idx 0..7 one per cycle -> out one cycle later reads 2,0,0,1,0,5,2,3. Then wrap idx 7->0 -> out = 2.
- Valid load: ld_en = 1, ld_data = 32'h1999_1231 while idx = 4 -> out shows the old digit 0. Scan then yields 1,9,9,9,1,2,3,1; bcd_err stays 0.
- Invalid load: ld_data = 32'h2001_0A23 -> bcd_err = 1 for one cycle, store unchanged (idx 5 still reads 5).
- Reset after load: load 32'h1999_1231, then pulse RST_N -> idx 0 reads 2 (BIRTHDAY restored).
- With BIRTHDAY_SEVSEG_EN: idx selecting digit 5 -> seg = 7'b1101101; digit 0 -> 7'b0111111.
